dvp_8bit_tx: RTL and testbench



---
 rtl/dvp_pkg.sv | 32 +++
 rtl/dvp_timing_gen.sv | 134 +++++++++++++
 rtl/dvp_8bit_tx.sv | 83 ++++++++
 tb/tb_dvp_8bit_tx.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dvp_pkg.sv
// Shared DVP definitions: FSM states, RGB565 layout and default timing for the
// transmit and receive sides of the camera path.
package dvp_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VSYNC  = 3'd1,
    VBP    = 3'd2,
    ACTIVE = 3'd3,
    HBLANK = 3'd4,
    VFP    = 3'd5
  } dvp_state_e;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  localparam int DVP_H_ACT     = 640;
  localparam int DVP_H_BLANK   = 160;
  localparam int DVP_V_ACT     = 480;
  localparam int DVP_VS_LINES  = 3;
  localparam int DVP_VBP_LINES = 17;
  localparam int DVP_VFP_LINES = 5;

  // Counter width that never collapses to zero bits for tiny test timings.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/dvp_timing_gen.sv
// DVP frame timing: pclk divider, tick generation, line/byte counters and the
// IDLE/VSYNC/VBP/ACTIVE/HBLANK/VFP state machine. State is exported for debug.
module dvp_timing_gen
  import dvp_pkg::*;
#(
  parameter int H_ACT     = DVP_H_ACT,
  parameter int H_BLANK   = DVP_H_BLANK,
  parameter int V_ACT     = DVP_V_ACT,
  parameter int VS_LINES  = DVP_VS_LINES,
  parameter int VBP_LINES = DVP_VBP_LINES,
  parameter int VFP_LINES = DVP_VFP_LINES
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       en,
  output logic       pclk,
  output logic       vsync,
  output logic       href,
  output logic       tick,
  output logic       pix_req,
  output logic       lo_req,
  output logic       pix_first,
  output logic       frame_done,
  output dvp_state_e state
);

  localparam int LINE   = 2 * H_ACT + H_BLANK;
  localparam int BW     = clog2_min1(LINE);
  localparam int VMAX_A = (VS_LINES > VBP_LINES) ? VS_LINES : VBP_LINES;
  localparam int VMAX_B = (V_ACT > VFP_LINES) ? V_ACT : VFP_LINES;
  localparam int VMAX   = (VMAX_A > VMAX_B) ? VMAX_A : VMAX_B;
  localparam int LW     = clog2_min1(VMAX);

  dvp_state_e      nxt_state;
  logic [BW-1:0]   byte_cnt, nxt_byte;
  logic [LW-1:0]   line_cnt, nxt_line;
  logic [LW-1:0]   lim_m1;
  logic            frame_end;

  // The edge on which pclk falls is the only edge that moves the video outputs.
  assign tick = (state != IDLE) && pclk;

  always_comb begin
    nxt_state = state;
    nxt_byte  = byte_cnt;
    nxt_line  = line_cnt;
    frame_end = 1'b0;
    lim_m1    = LW'(VS_LINES - 1);
    case (state)
      VBP:     lim_m1 = LW'(VBP_LINES - 1);
      VFP:     lim_m1 = LW'(VFP_LINES - 1);
      HBLANK:  lim_m1 = LW'(V_ACT - 1);
      default: ;
    endcase
    case (state)
      IDLE: begin
        if (en) nxt_state = VSYNC;
      end
      VSYNC, VBP, VFP: begin
        if (tick) begin
          if (byte_cnt == BW'(LINE - 1)) begin
            nxt_byte = '0;
            if (line_cnt == lim_m1) begin
              nxt_line = '0;
              if (state == VSYNC) begin
                nxt_state = VBP;
              end else if (state == VBP) begin
                nxt_state = ACTIVE;
              end else begin
                frame_end = 1'b1;
                nxt_state = en ? VSYNC : IDLE;
              end
            end else begin
              nxt_line = line_cnt + 1'b1;
            end
          end else begin
            nxt_byte = byte_cnt + 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (tick) begin
          if (byte_cnt == BW'(2 * H_ACT - 1)) begin
            nxt_byte  = '0;
            nxt_state = HBLANK;
          end else begin
            nxt_byte = byte_cnt + 1'b1;
          end
        end
      end
      HBLANK: begin
        if (tick) begin
          if (byte_cnt == BW'(H_BLANK - 1)) begin
            nxt_byte = '0;
            if (line_cnt == lim_m1) begin
              nxt_line  = '0;
              nxt_state = VFP;
            end else begin
              nxt_line  = line_cnt + 1'b1;
              nxt_state = ACTIVE;
            end
          end else begin
            nxt_byte = byte_cnt + 1'b1;
          end
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      byte_cnt   <= '0;
      line_cnt   <= '0;
      pclk       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= nxt_state;
      byte_cnt   <= nxt_byte;
      line_cnt   <= nxt_line;
      pclk       <= (state == IDLE) ? 1'b0 : ~pclk;
      frame_done <= frame_end;
    end
  end

  assign vsync     = (state == VSYNC);
  assign href      = (state == ACTIVE);
  // Requests look ahead to the byte that the coming tick will launch.
  assign pix_req   = tick && (nxt_state == ACTIVE) && !nxt_byte[0];
  assign lo_req    = tick && (nxt_state == ACTIVE) && nxt_byte[0];
  assign pix_first = (nxt_line == '0) && (nxt_byte == '0);

endmodule

// File: rtl/dvp_8bit_tx.sv
// DVP 8-bit transmitter: RGB565 valid/ready stream in, pclk/vsync/href/data out.
// Build option DVP_TX_RB_SWAP_EN sends pixels as {B,G,R}.
module dvp_8bit_tx
  import dvp_pkg::*;
#(
  parameter int H_ACT     = DVP_H_ACT,
  parameter int H_BLANK   = DVP_H_BLANK,
  parameter int V_ACT     = DVP_V_ACT,
  parameter int VS_LINES  = DVP_VS_LINES,
  parameter int VBP_LINES = DVP_VBP_LINES,
  parameter int VFP_LINES = DVP_VFP_LINES
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        en,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [15:0] pix_data,
  input  logic        pix_sof,
  output logic        cam_pclk,
  output logic        cam_vsync,
  output logic        cam_href,
  output logic [7:0]  cam_data,
  output logic        frame_done,
  output logic        underflow,
  output logic        sync_err
);

  // Stream handshake: a pixel moves on a rising clk where pix_valid and
  // pix_ready are both high; pix_ready never waits on pix_valid.

  dvp_state_e  tg_state;
  rgb565_t     px;
  logic [15:0] tx_word;
  logic [7:0]  lo_q;
  logic        tick, pix_req, lo_req, pix_first, flush, xfer;

  dvp_timing_gen #(
    .H_ACT(H_ACT), .H_BLANK(H_BLANK), .V_ACT(V_ACT),
    .VS_LINES(VS_LINES), .VBP_LINES(VBP_LINES), .VFP_LINES(VFP_LINES)
  ) u_timing (
    .clk(clk), .rstn(rstn), .en(en),
    .pclk(cam_pclk), .vsync(cam_vsync), .href(cam_href),
    .tick(tick), .pix_req(pix_req), .lo_req(lo_req), .pix_first(pix_first),
    .frame_done(frame_done), .state(tg_state)
  );

  assign px = pix_data;

`ifdef DVP_TX_RB_SWAP_EN
  assign tx_word = {px.b, px.g, px.r};
`else
  assign tx_word = px;
`endif

  // Before the first line, drain leftovers until a start-of-frame pixel heads the stream.
  assign flush     = (tg_state == VSYNC) || (tg_state == VBP);
  assign pix_ready = pix_req || (flush && !pix_sof);
  assign xfer      = pix_valid && pix_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cam_data  <= 8'h00;
      lo_q      <= 8'h00;
      underflow <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      if (tick) begin
        if (pix_req) begin
          cam_data <= xfer ? tx_word[15:8] : 8'h00;
          lo_q     <= xfer ? tx_word[7:0] : 8'h00;
        end else if (lo_req) begin
          cam_data <= lo_q;
        end else begin
          cam_data <= 8'h00;
        end
      end
      if (pix_req && !pix_valid) underflow <= 1'b1;
      if (pix_req && xfer && pix_sof && !pix_first) sync_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dvp_8bit_tx.sv
// Bench for dvp_8bit_tx with a tiny 4x2 frame; byte stream checked against an
// expected queue filled as pixels are queued for the source.
module tb_dvp_8bit_tx;

  localparam int H_ACT = 4, H_BLANK = 2, V_ACT = 2;
  localparam int VS_LINES = 1, VBP_LINES = 1, VFP_LINES = 1;
  localparam int LINE_P     = 2 * H_ACT + H_BLANK;
  localparam int VS_P       = VS_LINES * LINE_P;
  localparam int FIRST_HREF = (VS_LINES + VBP_LINES) * LINE_P;
  localparam int FRAME_P    = (VS_LINES + VBP_LINES + VFP_LINES + V_ACT) * LINE_P;

  logic        clk = 1'b0;
  logic        rstn, en, pix_valid, pix_ready, pix_sof;
  logic [15:0] pix_data;
  logic        cam_pclk, cam_vsync, cam_href, frame_done, underflow, sync_err;
  logic [7:0]  cam_data;

  int checks = 0;
  int failures = 0;
  logic [7:0]  exp_q[$];
  logic [16:0] src_q[$];

  int vs_rises = 0, done_cnt = 0, mon_lines = 0;

  always #5 clk = ~clk;

  dvp_8bit_tx #(
    .H_ACT(H_ACT), .H_BLANK(H_BLANK), .V_ACT(V_ACT),
    .VS_LINES(VS_LINES), .VBP_LINES(VBP_LINES), .VFP_LINES(VFP_LINES)
  ) dut (
    .clk(clk), .rstn(rstn), .en(en),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data), .pix_sof(pix_sof),
    .cam_pclk(cam_pclk), .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
    .frame_done(frame_done), .underflow(underflow), .sync_err(sync_err)
  );

  function automatic logic [15:0] tx_model(input logic [15:0] p);
`ifdef DVP_TX_RB_SWAP_EN
    return {p[4:0], p[10:5], p[15:11]};
`else
    return p;
`endif
  endfunction

  task automatic queue_pixel(input logic sof, input logic [15:0] p, input bit expect_out);
    logic [15:0] w;
    src_q.push_back({sof, p});
    if (expect_out) begin
      w = tx_model(p);
      exp_q.push_back(w[15:8]);
      exp_q.push_back(w[7:0]);
    end
  endtask

  task automatic queue_random_frame(input logic [15:0] first);
    queue_pixel(1'b1, first, 1'b1);
    for (int i = 1; i < H_ACT * V_ACT; i++)
      queue_pixel(1'b0, 16'($urandom_range(0, 16'hFFFF)), 1'b1);
  endtask

  // Source driver: presents the queue head, pops after an accepted transfer.
  task automatic source_loop();
    bit take;
    take = 1'b0;
    forever begin
      @(negedge clk);
      if (take && src_q.size() > 0) void'(src_q.pop_front());
      if (src_q.size() > 0) begin
        pix_valid = 1'b1;
        {pix_sof, pix_data} = src_q[0];
      end else begin
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        pix_data  = 16'h0000;
      end
      #1;
      take = pix_valid && pix_ready && rstn;
    end
  endtask

  // Monitor: one sample per cam_pclk period, taken on the clk falling edge.
  task automatic monitor_loop();
    bit prev_pclk, pv, ph, have_frame;
    int pcount, vs_run, hi_run, lo_run;
    logic [7:0] e;
    prev_pclk = 0; pv = 0; ph = 0; have_frame = 0;
    pcount = 0; vs_run = 0; hi_run = 0; lo_run = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        prev_pclk = 0; pv = 0; ph = 0; have_frame = 0;
        pcount = 0; vs_run = 0; hi_run = 0; lo_run = 0; mon_lines = 0;
      end else begin
        if (frame_done) done_cnt++;
        if (cam_pclk && !prev_pclk) begin
          if (cam_vsync && !pv) begin
            vs_rises++;
            if (have_frame) begin
              checks += 2;
              if (pcount !== FRAME_P) begin
                failures++;
                $display("FAIL frame_period got=%0d exp=%0d", pcount, FRAME_P);
              end
              if (mon_lines !== V_ACT) begin
                failures++;
                $display("FAIL lines_per_frame got=%0d exp=%0d", mon_lines, V_ACT);
              end
            end
            have_frame = 1; pcount = 0; vs_run = 0; mon_lines = 0;
          end
          if (!cam_vsync && pv) begin
            checks++;
            if (vs_run !== VS_P) begin
              failures++;
              $display("FAIL vsync_width got=%0d exp=%0d", vs_run, VS_P);
            end
          end
          if (cam_href && !ph && have_frame) begin
            checks++;
            if (mon_lines == 0 && pcount !== FIRST_HREF) begin
              failures++;
              $display("FAIL first_href got=%0d exp=%0d", pcount, FIRST_HREF);
            end else if (mon_lines != 0 && lo_run !== H_BLANK) begin
              failures++;
              $display("FAIL hblank_width got=%0d exp=%0d", lo_run, H_BLANK);
            end
            mon_lines++;
            hi_run = 0;
          end
          if (!cam_href && ph) begin
            checks++;
            if (hi_run !== 2 * H_ACT) begin
              failures++;
              $display("FAIL href_width got=%0d exp=%0d", hi_run, 2 * H_ACT);
            end
            lo_run = 0;
          end
          checks++;
          if (cam_href) begin
            hi_run++;
            if (exp_q.size() == 0) begin
              failures++;
              $display("FAIL byte_extra got=%h exp=none", cam_data);
            end else begin
              e = exp_q.pop_front();
              if (cam_data !== e) begin
                failures++;
                $display("FAIL byte got=%h exp=%h", cam_data, e);
              end
            end
          end else begin
            lo_run++;
            if (cam_data !== 8'h00) begin
              failures++;
              $display("FAIL data_blank got=%h exp=00", cam_data);
            end
          end
          if (cam_vsync) vs_run++;
          pcount++;
          pv = cam_vsync;
          ph = cam_href;
        end
        prev_pclk = cam_pclk;
      end
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    en   = 1'b0;
    repeat (3) @(negedge clk);
    src_q.delete();
    exp_q.delete();
    rstn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_vs(input int target, input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (vs_rises >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_done(input int target, input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (done_cnt >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_href(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (cam_href) begin ok = 1'b1; break; end
    end
  endtask

  // Runs exactly one frame: en held until vsync rises, then released.
  task automatic run_one_frame(output bit ok);
    bit ok1, ok2;
    int bd;
    bd = done_cnt;
    en = 1'b1;
    wait_vs(vs_rises + 1, 300, ok1);
    en = 1'b0;
    wait_done(bd + 1, 300, ok2);
    repeat (4) @(negedge clk);
    ok = ok1 && ok2;
  endtask

  task automatic test_reset();
    logic [14:0] outs;
    rstn = 1'b1;
    en   = 1'b0;
    #1 rstn = 1'b0;
    #2;
    outs = {cam_pclk, cam_vsync, cam_href, cam_data, frame_done, underflow, sync_err, pix_ready};
    checks++;
    if (outs !== 15'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", outs);
    end
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if ({cam_pclk, cam_vsync, pix_ready} !== 3'b000) begin
      failures++;
      $display("FAIL idle_quiet got=%b exp=000", {cam_pclk, cam_vsync, pix_ready});
    end
  endtask

  task automatic test_frames();
    bit ok1, ok2;
    int bd;
    logic [15:0] fa[8];
    fa = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h0F1E, 16'h2D3C, 16'h4B5A, 16'h6978};
    do_reset();
    bd = done_cnt;
    for (int i = 0; i < 8; i++) queue_pixel(i == 0, fa[i], 1'b1);
    queue_random_frame(16'($urandom_range(0, 16'hFFFF)));
    en = 1'b1;
    wait_vs(vs_rises + 2, 500, ok1);
    en = 1'b0;
    wait_done(bd + 2, 300, ok2);
    repeat (30) @(negedge clk);
    checks += 6;
    if (!(ok1 && ok2)) begin
      failures++;
      $display("FAIL frames_timeout got=%b%b exp=11", ok1, ok2);
    end
    if (done_cnt - bd !== 2) begin
      failures++;
      $display("FAIL frames_done_count got=%0d exp=2", done_cnt - bd);
    end
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL frames_bytes_left got=%0d exp=0", exp_q.size());
    end
    if (src_q.size() !== 0) begin
      failures++;
      $display("FAIL frames_pixels_left got=%0d exp=0", src_q.size());
    end
    if ({underflow, sync_err} !== 2'b00) begin
      failures++;
      $display("FAIL frames_flags got=%b exp=00", {underflow, sync_err});
    end
    if (mon_lines !== V_ACT) begin
      failures++;
      $display("FAIL frames_last_lines got=%0d exp=%0d", mon_lines, V_ACT);
    end
  endtask

  task automatic test_underflow();
    bit ok;
    do_reset();
    for (int i = 0; i < H_ACT; i++)
      queue_pixel(i == 0, 16'($urandom_range(0, 16'hFFFF)), 1'b1);
    for (int i = 0; i < 2 * H_ACT; i++) exp_q.push_back(8'h00);
    run_one_frame(ok);
    checks += 3;
    if (!ok) begin
      failures++;
      $display("FAIL underflow_timeout got=0 exp=1");
    end
    if ({underflow, sync_err} !== 2'b10) begin
      failures++;
      $display("FAIL underflow_flags got=%b exp=10", {underflow, sync_err});
    end
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL underflow_bytes_left got=%0d exp=0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [14:0] outs;
    queue_random_frame(16'hA5C3);
    en = 1'b1;
    wait_href(300, ok);
    repeat (3) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    outs = {cam_pclk, cam_vsync, cam_href, cam_data, frame_done, underflow, sync_err, pix_ready};
    checks += 2;
    if (!ok) begin
      failures++;
      $display("FAIL reset_mid_no_href got=0 exp=1");
    end
    if (outs !== 15'h0) begin
      failures++;
      $display("FAIL reset_mid_outputs got=%h exp=0", outs);
    end
    repeat (2) @(negedge clk);
    src_q.delete();
    exp_q.delete();
    queue_random_frame(16'h3C5A);
    rstn = 1'b1;
    run_one_frame(ok);
    checks += 3;
    if (!ok) begin
      failures++;
      $display("FAIL reset_mid_timeout got=0 exp=1");
    end
    if ({underflow, sync_err} !== 2'b00) begin
      failures++;
      $display("FAIL reset_mid_flags got=%b exp=00", {underflow, sync_err});
    end
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL reset_mid_bytes_left got=%0d exp=0", exp_q.size());
    end
  endtask

  task automatic test_flush();
    bit ok;
    do_reset();
    queue_pixel(1'b0, 16'hAAAA, 1'b0);
    queue_pixel(1'b0, 16'hBBBB, 1'b0);
    queue_pixel(1'b0, 16'hCCCC, 1'b0);
    queue_random_frame(16'h5A5A);
    run_one_frame(ok);
    checks += 4;
    if (!ok) begin
      failures++;
      $display("FAIL flush_timeout got=0 exp=1");
    end
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL flush_bytes_left got=%0d exp=0", exp_q.size());
    end
    if (src_q.size() !== 0) begin
      failures++;
      $display("FAIL flush_pixels_left got=%0d exp=0", src_q.size());
    end
    if ({underflow, sync_err} !== 2'b00) begin
      failures++;
      $display("FAIL flush_flags got=%b exp=00", {underflow, sync_err});
    end
  endtask

  task automatic test_sync_err();
    bit ok;
    do_reset();
    for (int i = 0; i < H_ACT * V_ACT; i++)
      queue_pixel(i == 0 || i == 2, 16'($urandom_range(0, 16'hFFFF)), 1'b1);
    run_one_frame(ok);
    checks += 3;
    if (!ok) begin
      failures++;
      $display("FAIL sync_err_timeout got=0 exp=1");
    end
    if ({underflow, sync_err} !== 2'b01) begin
      failures++;
      $display("FAIL sync_err_flags got=%b exp=01", {underflow, sync_err});
    end
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL sync_err_bytes_left got=%0d exp=0", exp_q.size());
    end
  endtask

  task automatic test_en_drop();
    bit ok1, ok2, pclk_seen;
    int bd, bv;
    do_reset();
    bd = done_cnt;
    queue_random_frame(16'hF800);
    en = 1'b1;
    wait_href(300, ok1);
    en = 1'b0;
    wait_done(bd + 1, 300, ok2);
    bv = vs_rises;
    pclk_seen = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (cam_pclk) pclk_seen = 1'b1;
    end
    checks += 5;
    if (!(ok1 && ok2)) begin
      failures++;
      $display("FAIL en_drop_timeout got=%b%b exp=11", ok1, ok2);
    end
    if (done_cnt - bd !== 1) begin
      failures++;
      $display("FAIL en_drop_done_count got=%0d exp=1", done_cnt - bd);
    end
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL en_drop_bytes_left got=%0d exp=0", exp_q.size());
    end
    if (pclk_seen !== 1'b0) begin
      failures++;
      $display("FAIL en_drop_pclk_stopped got=1 exp=0");
    end
    if (vs_rises !== bv || cam_vsync !== 1'b0) begin
      failures++;
      $display("FAIL en_drop_vsync got=%0d/%b exp=%0d/0", vs_rises, cam_vsync, bv);
    end
  endtask

  initial begin
    rstn      = 1'b1;
    en        = 1'b0;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    pix_data  = 16'h0000;
    fork
      source_loop();
      monitor_loop();
    join_none
    test_reset();
    test_frames();
    test_underflow();
    test_reset_mid();
    test_flush();
    test_sync_err();
    test_en_drop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
